// File: rtl/symb_pll_lock_ctrl.sv
// symb_pll_lock_ctrl
//   Sequencer and lock monitor for the symbol clock PLL divider block.
//   On start the requested ref/fbk/vco divide values are captured and driven
//   to the dividers. The dividers are held in reset, released, and given a
//   settle time. Edge counts of clk_ref_in and clk_fbk_in are then compared
//   over back-to-back windows to declare lock. Failed acquisitions are retried
//   until the retry limit is reached, which raises fault.
//
// Build option: SYMB_PLL_AUTO_RELOCK_EN
//   defined   - loss of lock re-enters LOAD with the same divider values
//   undefined - loss of lock returns to IDLE and waits for start
//
// Ports
//   clk, rs_n               system clock, async active-low reset
//   start                   1-cycle pulse, (re)starts acquisition
//   ref_req/fbk_req/vco_req requested divide values (captured on start)
//   win_len, tol            window length in clk cycles (0 -> 1), tolerance
//   clk_ref_in, clk_fbk_in  asynchronous comparator clocks (< clk/2)
//   ref_div/fbk_div/vco_div divide values to the dividers
//   div_rs                  active-high divider reset
//   locked, lock_lost       lock status and 1-cycle loss-of-lock pulse
//   fault                   acquisition gave up
//   state                   current state code
//
// state      | meaning
// IDLE   (0) | dividers held in reset, waiting for start
// LOAD   (1) | divide values applied, div_rs held for RS_CYC cycles
// SETTLE (2) | dividers running, waiting SETTLE_CYC cycles
// MEAS   (3) | measuring windows until LOCK_WINS consecutive good ones
// LOCKED (4) | locked, windows keep running to detect loss of lock
// FAULT  (5) | retries exhausted, held until start
module symb_pll_lock_ctrl #(
  parameter int SETTLE_CYC = 4096,
  parameter int LOCK_WINS  = 4,
  parameter int MAX_RETRY  = 3,
  parameter int RS_CYC     = 8
) (
  input  logic        clk,
  input  logic        rs_n,
  input  logic        start,
  input  logic [15:0] ref_req,
  input  logic [15:0] fbk_req,
  input  logic [15:0] vco_req,
  input  logic [15:0] win_len,
  input  logic [7:0]  tol,
  input  logic        clk_ref_in,
  input  logic        clk_fbk_in,
  output logic [15:0] ref_div,
  output logic [15:0] fbk_div,
  output logic [15:0] vco_div,
  output logic        div_rs,
  output logic        locked,
  output logic        lock_lost,
  output logic        fault,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_MEAS   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic [2:0]  state_nxt;
  logic [15:0] tmr, tmr_nxt;
  logic [7:0]  good_cnt, good_nxt;
  logic [7:0]  retry_cnt, retry_nxt;
  logic        lost_nxt;
  logic        capture;

  // two synchronizer flops plus one history flop for rising-edge detect
  logic [2:0]  ref_sync, fbk_sync;
  logic        ref_edge, fbk_edge;

  logic [15:0] win_cnt;
  logic [15:0] ref_cnt, fbk_cnt;
  logic [15:0] ref_cnt_nx, fbk_cnt_nx;
  logic [15:0] cnt_diff;
  logic [15:0] win_len_eff;
  logic [7:0]  tol_q;
  logic        win_done, win_good;
  logic        meas_now, meas_nxt, win_end;

  assign ref_edge    = ref_sync[1] & ~ref_sync[2];
  assign fbk_edge    = fbk_sync[1] & ~fbk_sync[2];
  assign ref_cnt_nx  = (ref_edge && ref_cnt != 16'hFFFF) ? ref_cnt + 16'd1 : ref_cnt;
  assign fbk_cnt_nx  = (fbk_edge && fbk_cnt != 16'hFFFF) ? fbk_cnt + 16'd1 : fbk_cnt;
  assign cnt_diff    = (ref_cnt_nx >= fbk_cnt_nx) ? ref_cnt_nx - fbk_cnt_nx
                                                  : fbk_cnt_nx - ref_cnt_nx;
  assign win_len_eff = (win_len == 16'd0) ? 16'd1 : win_len;
  assign meas_now    = (state == S_MEAS) || (state == S_LOCKED);
  assign meas_nxt    = (state_nxt == S_MEAS) || (state_nxt == S_LOCKED);
  // win_cnt holds the cycles left in the window, including the current one
  assign win_end     = meas_now && (win_cnt == 16'd1);

  assign div_rs = (state == S_IDLE) || (state == S_LOAD);
  assign locked = (state == S_LOCKED);
  assign fault  = (state == S_FAULT);

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    good_nxt  = good_cnt;
    retry_nxt = retry_cnt;
    lost_nxt  = 1'b0;
    capture   = 1'b0;
    if (start) begin
      state_nxt = S_LOAD;
      tmr_nxt   = 16'(RS_CYC - 1);
      good_nxt  = 8'd0;
      retry_nxt = 8'd0;
      capture   = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_FAULT: ;
        S_LOAD: begin
          if (tmr == 16'd0) begin
            state_nxt = S_SETTLE;
            tmr_nxt   = 16'(SETTLE_CYC - 1);
          end else begin
            tmr_nxt = tmr - 16'd1;
          end
        end
        S_SETTLE: begin
          if (tmr == 16'd0) state_nxt = S_MEAS;
          else              tmr_nxt   = tmr - 16'd1;
        end
        S_MEAS: begin
          if (win_done) begin
            if (win_good) begin
              good_nxt = good_cnt + 8'd1;
              if (good_nxt == 8'(LOCK_WINS)) state_nxt = S_LOCKED;
            end else begin
              good_nxt  = 8'd0;
              retry_nxt = retry_cnt + 8'd1;
              if (retry_nxt > 8'(MAX_RETRY)) begin
                state_nxt = S_FAULT;
              end else begin
                state_nxt = S_LOAD;
                tmr_nxt   = 16'(RS_CYC - 1);
              end
            end
          end
        end
        S_LOCKED: begin
          if (win_done && !win_good) begin
            lost_nxt = 1'b1;
            good_nxt = 8'd0;
`ifdef SYMB_PLL_AUTO_RELOCK_EN
            state_nxt = S_LOAD;
            tmr_nxt   = 16'(RS_CYC - 1);
            retry_nxt = 8'd0;
`else
            state_nxt = S_IDLE;
`endif
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state     <= S_IDLE;
      tmr       <= 16'd0;
      good_cnt  <= 8'd0;
      retry_cnt <= 8'd0;
      lock_lost <= 1'b0;
      ref_div   <= 16'd1;
      fbk_div   <= 16'd1;
      vco_div   <= 16'd1;
      ref_sync  <= 3'b000;
      fbk_sync  <= 3'b000;
      win_cnt   <= 16'd0;
      ref_cnt   <= 16'd0;
      fbk_cnt   <= 16'd0;
      tol_q     <= 8'd0;
      win_done  <= 1'b0;
      win_good  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      good_cnt  <= good_nxt;
      retry_cnt <= retry_nxt;
      lock_lost <= lost_nxt;
      ref_sync  <= {ref_sync[1:0], clk_ref_in};
      fbk_sync  <= {fbk_sync[1:0], clk_fbk_in};
      if (capture) begin
        ref_div <= ref_req;
        fbk_div <= fbk_req;
        vco_div <= vco_req;
      end
      if (!meas_nxt) begin
        // leaving measurement (or start): drop any window in progress
        win_cnt  <= 16'd0;
        ref_cnt  <= 16'd0;
        fbk_cnt  <= 16'd0;
        win_done <= 1'b0;
      end else if (!meas_now || win_end) begin
        // first window, or back-to-back restart; the ending window's verdict
        // includes edges seen in its last cycle
        win_done <= win_end;
        if (win_end) win_good <= (cnt_diff <= {8'd0, tol_q});
        win_cnt  <= win_len_eff;
        ref_cnt  <= 16'd0;
        fbk_cnt  <= 16'd0;
        tol_q    <= tol;
      end else begin
        win_done <= 1'b0;
        win_cnt  <= win_cnt - 16'd1;
        ref_cnt  <= ref_cnt_nx;
        fbk_cnt  <= fbk_cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_symb_pll_lock_ctrl.sv
`timescale 1ns/1ps
module tb_symb_pll_lock_ctrl;
  localparam int SETTLE = 64;
  localparam int LWINS  = 4;
  localparam int MRETRY = 3;
  localparam int RSC    = 8;
`ifdef SYMB_PLL_AUTO_RELOCK_EN
  localparam int LOSS_ST = 1;
`else
  localparam int LOSS_ST = 0;
`endif

  logic        clk = 1'b0;
  logic        rs_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ref_req = 16'd1, fbk_req = 16'd1, vco_req = 16'd1;
  logic [15:0] win_len = 16'd0;
  logic [7:0]  tol = 8'd0;
  logic        clk_ref_in = 1'b0, clk_fbk_in = 1'b0;
  logic [15:0] ref_div, fbk_div, vco_div;
  logic        div_rs, locked, lock_lost, fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  symb_pll_lock_ctrl #(
    .SETTLE_CYC(SETTLE), .LOCK_WINS(LWINS), .MAX_RETRY(MRETRY), .RS_CYC(RSC)
  ) dut (
    .clk(clk), .rs_n(rs_n), .start(start),
    .ref_req(ref_req), .fbk_req(fbk_req), .vco_req(vco_req),
    .win_len(win_len), .tol(tol),
    .clk_ref_in(clk_ref_in), .clk_fbk_in(clk_fbk_in),
    .ref_div(ref_div), .fbk_div(fbk_div), .vco_div(vco_div),
    .div_rs(div_rs), .locked(locked), .lock_lost(lock_lost),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // comparator clocks: period in clk cycles, toggles offset 3ns from clk edges
  int ref_half = 20, fbk_half = 20;
  bit ref_en = 1'b0, fbk_en = 1'b0;
  initial begin
    #3;
    forever begin
      #(ref_half);
      if (ref_en) clk_ref_in = ~clk_ref_in;
    end
  end
  initial begin
    #3;
    forever begin
      #(fbk_half);
      if (fbk_en) clk_fbk_in = ~clk_fbk_in;
    end
  end

  int lost_cnt = 0, load_entries = 0, locked_cycles = 0;
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    if (lock_lost) lost_cnt++;
    if (state == 3'd1 && prev_state != 3'd1) load_entries++;
    if (locked) locked_cycles++;
    prev_state = state;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_clk(input int pr, input int pf);
    ref_en = (pr != 0);
    fbk_en = (pf != 0);
    if (pr != 0) ref_half = pr * 5;
    if (pf != 0) fbk_half = pf * 5;
  endtask

  task automatic do_reset();
    @(negedge clk); rs_n = 1'b0;
    @(negedge clk); rs_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_for(input logic [2:0] s, input int max, output int n);
    n = 0;
    while (state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Reference model: with clock periods dividing the window length, every
  // window sees exactly L/p edges, so the verdict is fixed for the whole run.
  task automatic run_acq(input string tag, input int pr, input int pf,
                         input int l, input int t);
    int leff, dr, df, diff, cyc, ld0, lk0, lo, max;
    bit exp_lock;
    do_reset();
    set_clk(pr, pf);
    win_len = 16'(l);
    tol     = 8'(t);
    leff = (l == 0) ? 1 : l;
    dr   = (pr == 0) ? 0 : leff / pr;
    df   = (pf == 0) ? 0 : leff / pf;
    diff = (dr > df) ? dr - df : df - dr;
    exp_lock = (diff <= t);
    max  = (MRETRY + 1) * (RSC + SETTLE + 2 * leff + 4) + 100;
    repeat (20) @(negedge clk);
    #1;
    ld0 = load_entries;
    lk0 = locked_cycles;
    pulse_start();
    cyc = 0;
    while (!(locked || fault) && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    if (exp_lock) begin
      lo = RSC + SETTLE + LWINS * leff;
      chk({tag, " locked"}, locked, 1);
      chk({tag, " state"}, state, 4);
      chk({tag, " lock time in range"}, (cyc >= lo && cyc <= lo + 4), 1);
      chk({tag, " load entries"}, load_entries - ld0, 1);
    end else begin
      chk({tag, " fault"}, fault, 1);
      chk({tag, " state"}, state, 5);
      chk({tag, " load entries"}, load_entries - ld0, MRETRY + 1);
      chk({tag, " never locked"}, locked_cycles - lk0, 0);
      chk({tag, " div_rs low"}, div_rs, 0);
    end
  endtask

  int n, l0, bad;
  int per [4] = '{4, 5, 8, 10};
  int pr, pf, l, t;

  initial begin
    #12;
    chk("rst ref_div", ref_div, 1);
    chk("rst fbk_div", fbk_div, 1);
    chk("rst vco_div", vco_div, 1);
    chk("rst div_rs", div_rs, 1);
    chk("rst locked", locked, 0);
    chk("rst lock_lost", lock_lost, 0);
    chk("rst fault", fault, 0);
    chk("rst state", state, 0);
    @(negedge clk); rs_n = 1'b1;

    // zero-length windows with no comparator edges: every window good
    run_acq("win0", 0, 0, 0, 0);

    // start while locked goes to LOAD without a lock_lost pulse
    #1 l0 = lost_cnt;
    pulse_start();
    chk("start_in_locked state", state, 1);
    repeat (3) @(negedge clk);
    #1 chk("start_in_locked no lost", lost_cnt - l0, 0);

    // tolerance boundary: 5 ref edges vs 0 fbk edges per window
    run_acq("tol_eq_diff", 8, 0, 40, 5);
    run_acq("tol_below_diff", 8, 0, 40, 4);

    // loss of lock
    run_acq("pre_loss", 8, 8, 40, 0);
    @(negedge clk);
    #1 l0 = lost_cnt;
    set_clk(8, 4);
    n = 0;
    while (!lock_lost && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("loss pulse seen", lock_lost, 1);
    chk("loss locked", locked, 0);
    chk("loss state", state, LOSS_ST);
    n = 0;
    while (!(state == 3'd0 || state == 3'd5) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #1 chk("loss pulse count", lost_cnt - l0, 1);

    // restart mid-MEAS recaptures the request
    do_reset();
    set_clk(0, 0);
    win_len = 16'd1000; tol = 8'd0;
    ref_req = 16'd10; fbk_req = 16'd33; vco_req = 16'd7;
    pulse_start();
    wait_for(3'd3, 200, n);
    chk("reach meas", state, 3);
    ref_req = 16'd20;
    pulse_start();
    chk("restart state", state, 1);
    chk("restart ref_div", ref_div, 20);
    chk("restart fbk_div", fbk_div, 33);
    chk("restart vco_div", vco_div, 7);
    ref_req = 16'd55;
    n = 0;
    while (div_rs && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("div_rs high cycles", n, RSC);
    chk("req ignored until start", ref_div, 20);

    // randomized acquisitions
    for (int i = 0; i < 6; i++) begin
      pr = per[$urandom_range(0, 3)];
      pf = ($urandom_range(0, 1) == 1) ? pr : per[$urandom_range(0, 3)];
      l  = 40 * $urandom_range(1, 3);
      t  = $urandom_range(0, 8);
      run_acq($sformatf("rnd%0d pr%0d pf%0d l%0d t%0d", i, pr, pf, l, t), pr, pf, l, t);
    end

    // async reset in the middle of SETTLE
    do_reset();
    set_clk(0, 0);
    win_len = 16'd1000;
    pulse_start();
    wait_for(3'd2, 50, n);
    chk("reach settle", state, 2);
    chk("settle ref_div", ref_div, 55);
    repeat (10) @(negedge clk);
    #2 rs_n = 1'b0;
    #1;
    chk("async rst state", state, 0);
    chk("async rst div_rs", div_rs, 1);
    chk("async rst ref_div", ref_div, 1);
    chk("async rst locked", locked, 0);
    chk("async rst fault", fault, 0);
    chk("async rst lock_lost", lock_lost, 0);
    @(negedge clk); rs_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (state !== 3'd0) bad++;
    end
    chk("idle after reset release", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
